pcs_tx_scrambler: RTL and testbench
===================================

Name: pcs_tx_scrambler

Overview:
- Self-synchronous 64b/66b TX scrambler, polynomial G(x) = 1 + x^39 + x^58.
- Sits directly downstream of the TX encoder FSM and consumes its 66-bit coded block.
- Scrambles the 64-bit payload and passes the 2-bit sync header through unscrambled.
- Output feeds the alignment-marker insertion / lane distribution stage.

Parameters:
- NB_DATA_CODED, 66, coded block width. Layout: header [65:64], payload [63:0].
- NB_SCR_STATE, 58, scrambler state length.
- SCR_SEED, 58'h3FFFFFFFFFFFFFF (all ones), state loaded at reset.

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  clock enable shared with the TX path
- i_valid  in  1  qualifies i_tx_coded for this cycle
- i_bypass  in  1  test mode: payload passes unscrambled
- i_tx_coded  in  66  coded block from the encoder FSM
- o_tx_scrambled  out  66  scrambled block
- o_valid  out  1  qualifies o_tx_scrambled

Behaviour:
- Reset: single clock, synchronous, active-high. The reset names and polarity are fixed.
  - state <= SCR_SEED, o_tx_scrambled <= 66'h0, o_valid <= 0.
  - Reset asserted mid-stream discards any in-flight block. The next accepted block is scrambled from SCR_SEED.
- Accept condition: acc = i_enable & i_valid.
- Latency: exactly 1 clock, input to registered output.
- Every cycle: o_valid <= acc.
- When acc = 0: o_tx_scrambled and the scrambler state hold their values.
- Transmit order:
  - Payload bit 63 is sent first and bit 0 last; this is the order used by the encoder, where the block-type octet is at [63:56].
  - Scrambling proceeds bit-serially in this order, unrolled to 64 bits per clock.
- Recurrence, with state[k] = scrambled output bit sent k+1 bits earlier:
  - out = in ^ state[38] ^ state[57].
  - After each bit: state <= {state[56:0], out}.
  - After a 64-bit word, the new state equals the last 58 scrambled payload bits: state[57:0] = scr[57:0]. Here scr[0] is the most recently sent bit, i.e. payload bit 0.
- Header: o_tx_scrambled[65:64] <= i_tx_coded[65:64] unchanged.
  - Applies to every header value, including illegal 2'b00 and 2'b11.
  - Header validation belongs to the encoder.
- Bypass (i_bypass = 1 while acc = 1):
  - Payload is copied unchanged.
  - State is NOT updated.
  - Toggling bypass mid-stream needs no reset.
- Data independence: the block is content-agnostic. Error and LBLOCK control blocks are scrambled like any other block.
- No backpressure: the downstream stage must sink o_valid every cycle.

Decomposition:
- Shared package pcs_tx_pkg holds:
  - SCR_TAP_A = 38, SCR_TAP_B = 57
  - SCR_SEED
  - header constants SH_DATA = 2'b01, SH_CTRL = 2'b10
- Sub-module scrambler_step (purely combinational):
  - Inputs: 64-bit payload, 58-bit state.
  - Outputs: 64-bit scrambled payload and next state.
  - Built as an unrolled loop.
  - Reused by the RX descrambler in its feed-forward form.
- The top-level module holds only the registers, accept logic and bypass mux.

Test Plan:
- Reset check: hold i_reset 3 cycles with i_valid = 1 → o_valid = 0, o_tx_scrambled = 66'h0. Stays so 1 cycle after release if i_valid = 0.
- Seed vector: after reset, one block 66'h2_0000_0000_0000_0000 with acc = 1 → next cycle o_tx_scrambled = 66'h2_0000_0000_01FF_FFC0, o_valid = 1.
- Hold / enable:
  - Feed that block, then drop i_enable for 5 cycles with i_valid = 1 → output and state frozen, o_valid = 0.
  - Resume with a zero data block, header 2'b01 → payload matches the golden model continuing from the frozen state.
- Bypass: i_bypass = 1, input 66'h1_DEAD_BEEF_0123_4567 → output identical. Then clear bypass and send zeros → result equals the no-bypass golden sequence, i.e. the state was untouched.
- Round trip: 10,000 random blocks with random i_valid gaps, through the DUT and then a reference descrambler (in ^ in_{-39} ^ in_{-58}) → original payloads recovered bit-exact after the first block. Headers match on every block.
- Reset mid-stream: assert i_reset between two valid blocks → the first post-reset zero block again yields payload 64'h0000_0000_01FF_FFC0.

Source files
------------

// File: rtl/pcs_tx_pkg.sv
// Shared constants for the 64b/66b TX path: block geometry, scrambler taps and seed,
// and the legal sync-header codes.
package pcs_tx_pkg;

  localparam int NB_DATA_CODED = 66;
  localparam int NB_PAYLOAD    = 64;
  localparam int NB_HEADER     = NB_DATA_CODED - NB_PAYLOAD;
  localparam int NB_SCR_STATE  = 58;

  // Tap indices into the state, where state[k] is the scrambled bit sent k+1 bits earlier.
  localparam int SCR_TAP_A = 38;
  localparam int SCR_TAP_B = 57;

  localparam logic [NB_SCR_STATE-1:0] SCR_SEED = {NB_SCR_STATE{1'b1}};

  localparam logic [NB_HEADER-1:0] SH_DATA = 2'b01;
  localparam logic [NB_HEADER-1:0] SH_CTRL = 2'b10;

endpackage

// File: rtl/scrambler_step.sv
// One 64-bit step of the self-synchronous scrambler G(x) = 1 + x^39 + x^58.
// Payload bit 63 is sent first; the history and the new bits share one MSB-first chain.
module scrambler_step
  import pcs_tx_pkg::*;
(
  input  logic [NB_PAYLOAD-1:0]   payload_i,
  input  logic [NB_SCR_STATE-1:0] state_i,
  output logic [NB_PAYLOAD-1:0]   scrambled_o,
  output logic [NB_SCR_STATE-1:0] next_state_o
);

  // chain[63:0] holds the new scrambled bits, chain[121:64] the prior history, so the
  // bit sent d positions before chain[i] sits at chain[i+d].
  logic [NB_SCR_STATE+NB_PAYLOAD-1:0] chain;

  always_comb begin
    chain = {state_i, {NB_PAYLOAD{1'b0}}};
    for (int i = NB_PAYLOAD - 1; i >= 0; i--) begin
      chain[i] = payload_i[i] ^ chain[i + SCR_TAP_A + 1] ^ chain[i + SCR_TAP_B + 1];
    end
  end

  assign scrambled_o  = chain[NB_PAYLOAD-1:0];
  assign next_state_o = chain[NB_SCR_STATE-1:0];

endmodule

// File: rtl/pcs_tx_scrambler.sv
// 64b/66b TX scrambler: registers, accept logic and bypass mux around scrambler_step.
// Sync header passes through untouched; one clock of latency.
module pcs_tx_scrambler
  import pcs_tx_pkg::*;
(
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic                     i_bypass,
  input  logic [NB_DATA_CODED-1:0] i_tx_coded,
  output logic [NB_DATA_CODED-1:0] o_tx_scrambled,
  output logic                     o_valid
);

  logic                     acc;
  logic [NB_SCR_STATE-1:0]  state_q, state_d;
  logic [NB_DATA_CODED-1:0] data_q, data_d;
  logic                     valid_q;
  logic [NB_PAYLOAD-1:0]    scr_payload;
  logic [NB_SCR_STATE-1:0]  scr_next_state;

  assign acc = i_enable & i_valid;

  scrambler_step u_step (
    .payload_i    (i_tx_coded[NB_PAYLOAD-1:0]),
    .state_i      (state_q),
    .scrambled_o  (scr_payload),
    .next_state_o (scr_next_state)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (acc) begin
      data_d[NB_DATA_CODED-1:NB_PAYLOAD] = i_tx_coded[NB_DATA_CODED-1:NB_PAYLOAD];
      // Bypass leaves the history alone so scrambling resumes seamlessly afterwards.
      if (i_bypass) begin
        data_d[NB_PAYLOAD-1:0] = i_tx_coded[NB_PAYLOAD-1:0];
      end else begin
        data_d[NB_PAYLOAD-1:0] = scr_payload;
        state_d                = scr_next_state;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= SCR_SEED;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= acc;
    end
  end

  assign o_tx_scrambled = data_q;
  assign o_valid        = valid_q;

endmodule

// File: tb/tb_pcs_tx_scrambler.sv
// Self-checking bench for pcs_tx_scrambler against a bit-serial reference scrambler
// and descrambler kept as bit-history queues.
module tb_pcs_tx_scrambler;
  import pcs_tx_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_valid;
  logic        i_bypass;
  logic [65:0] i_tx_coded;
  logic [65:0] o_tx_scrambled;
  logic        o_valid;

  int errors = 0;
  int checks = 0;

  bit tx_hist[$];
  bit rx_hist[$];

  logic [65:0] exp_data;

  pcs_tx_scrambler dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_valid        (i_valid),
    .i_bypass       (i_bypass),
    .i_tx_coded     (i_tx_coded),
    .o_tx_scrambled (o_tx_scrambled),
    .o_valid        (o_valid)
  );

  always #5 i_clock = ~i_clock;

  // Serial model: each sent bit = in ^ bit sent 39 earlier ^ bit sent 58 earlier.
  task automatic model_reset();
    tx_hist.delete();
    repeat (58) tx_hist.push_back(1'b1);
  endtask

  function automatic logic [63:0] model_scr(input logic [63:0] p);
    logic [63:0] r;
    bit b;
    r = '0;
    for (int j = 63; j >= 0; j--) begin
      b = p[j] ^ tx_hist[19] ^ tx_hist[0];
      r[j] = b;
      tx_hist.push_back(b);
      tx_hist.delete(0);
    end
    return r;
  endfunction

  function automatic logic [63:0] model_descr(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int j = 63; j >= 0; j--) begin
      r[j] = s[j] ^ rx_hist[19] ^ rx_hist[0];
      rx_hist.push_back(s[j]);
      rx_hist.delete(0);
    end
    return r;
  endfunction

  task automatic set_in(input logic rst, input logic en, input logic vld,
                        input logic byp, input logic [65:0] blk);
    i_reset    = rst;
    i_enable   = en;
    i_valid    = vld;
    i_bypass   = byp;
    i_tx_coded = blk;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b0, {$urandom_range(0, 3), $urandom, $urandom});
      @(negedge i_clock);
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid cyc=%0d got=%b exp=0", c, o_valid);
      end
      checks++;
      if (o_tx_scrambled !== 66'h0) begin
        errors++;
        $display("FAIL reset_data cyc=%0d got=%h exp=0", c, o_tx_scrambled);
      end
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 66'h0);
    @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b0 || o_tx_scrambled !== 66'h0) begin
      errors++;
      $display("FAIL reset_release got_valid=%b got=%h exp_valid=0 exp=0", o_valid, o_tx_scrambled);
    end
    model_reset();
    exp_data = 66'h0;
    $display("reset: outputs cleared");
  endtask

  task automatic test_seed();
    logic [63:0] m;
    set_in(1'b0, 1'b1, 1'b1, 1'b0, {SH_CTRL, 64'h0});
    m = model_scr(64'h0);
    exp_data = {SH_CTRL, m};
    @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b1 || o_tx_scrambled !== 66'h2_0000_0000_01FF_FFC0) begin
      errors++;
      $display("FAIL seed_vector got_valid=%b got=%h exp_valid=1 exp=%h",
               o_valid, o_tx_scrambled, 66'h2_0000_0000_01FF_FFC0);
    end
    $display("seed: in=%h out=%h", i_tx_coded, o_tx_scrambled);
  endtask

  task automatic test_hold();
    logic [63:0] m;
    set_in(1'b0, 1'b1, 1'b1, 1'b0, {SH_CTRL, 64'h0});
    m = model_scr(64'h0);
    exp_data = {SH_CTRL, m};
    @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b1 || o_tx_scrambled !== exp_data) begin
      errors++;
      $display("FAIL hold_feed got=%h exp=%h valid=%b", o_tx_scrambled, exp_data, o_valid);
    end
    for (int c = 0; c < 5; c++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b0, {$urandom_range(0, 3), $urandom, $urandom});
      @(negedge i_clock);
      checks++;
      if (o_valid !== 1'b0 || o_tx_scrambled !== exp_data) begin
        errors++;
        $display("FAIL hold_frozen cyc=%0d got=%h exp=%h valid=%b exp_valid=0",
                 c, o_tx_scrambled, exp_data, o_valid);
      end
    end
    set_in(1'b0, 1'b1, 1'b1, 1'b0, {SH_DATA, 64'h0});
    m = model_scr(64'h0);
    exp_data = {SH_DATA, m};
    @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b1 || o_tx_scrambled !== exp_data) begin
      errors++;
      $display("FAIL hold_resume got=%h exp=%h valid=%b", o_tx_scrambled, exp_data, o_valid);
    end
    $display("hold: resumed out=%h", o_tx_scrambled);
  endtask

  task automatic test_bypass();
    logic [63:0] m;
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 66'h1_DEAD_BEEF_0123_4567);
    exp_data = 66'h1_DEAD_BEEF_0123_4567;
    @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b1 || o_tx_scrambled !== exp_data) begin
      errors++;
      $display("FAIL bypass_copy got=%h exp=%h", o_tx_scrambled, exp_data);
    end
    for (int c = 0; c < 2; c++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0, {SH_DATA, 64'h0});
      m = model_scr(64'h0);
      exp_data = {SH_DATA, m};
      @(negedge i_clock);
      checks++;
      if (o_valid !== 1'b1 || o_tx_scrambled !== exp_data) begin
        errors++;
        $display("FAIL bypass_after cyc=%0d got=%h exp=%h", c, o_tx_scrambled, exp_data);
      end
    end
    $display("bypass: post-bypass out=%h", o_tx_scrambled);
  endtask

  task automatic test_round_trip();
    int blocks = 0;
    int cyc = 0;
    logic vld, en, acc_exp;
    logic [1:0] hdr;
    logic [63:0] pay, m, rec;
    rx_hist.delete();
    repeat (58) rx_hist.push_back(1'b0);
    while (blocks < 10000 && cyc < 40000) begin
      cyc++;
      vld = ($urandom_range(0, 3) != 0);
      en  = ($urandom_range(0, 7) != 0);
      hdr = 2'($urandom_range(0, 3));
      pay = {$urandom, $urandom};
      acc_exp = vld & en;
      set_in(1'b0, en, vld, 1'b0, {hdr, pay});
      if (acc_exp) begin
        m = model_scr(pay);
        exp_data = {hdr, m};
      end
      @(negedge i_clock);
      checks++;
      if (o_valid !== acc_exp || o_tx_scrambled !== exp_data) begin
        errors++;
        $display("FAIL round_trip_out cyc=%0d got=%h exp=%h valid=%b exp_valid=%b",
                 cyc, o_tx_scrambled, exp_data, o_valid, acc_exp);
      end
      if (acc_exp) begin
        rec = model_descr(o_tx_scrambled[63:0]);
        checks++;
        if (o_tx_scrambled[65:64] !== hdr) begin
          errors++;
          $display("FAIL round_trip_header blk=%0d got=%b exp=%b", blocks, o_tx_scrambled[65:64], hdr);
        end
        if (blocks > 0) begin
          checks++;
          if (rec !== pay) begin
            errors++;
            $display("FAIL round_trip_payload blk=%0d got=%h exp=%h", blocks, rec, pay);
          end
        end
        blocks++;
      end
    end
    checks++;
    if (blocks != 10000) begin
      errors++;
      $display("FAIL round_trip_count got=%0d exp=10000", blocks);
    end
    $display("round_trip: %0d blocks in %0d cycles", blocks, cyc);
  endtask

  task automatic test_reset_midstream();
    logic [63:0] m;
    set_in(1'b0, 1'b1, 1'b1, 1'b0, {SH_DATA, $urandom, $urandom});
    m = model_scr(i_tx_coded[63:0]);
    exp_data = {SH_DATA, m};
    @(negedge i_clock);
    checks++;
    if (o_tx_scrambled !== exp_data) begin
      errors++;
      $display("FAIL midreset_pre got=%h exp=%h", o_tx_scrambled, exp_data);
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b0, {SH_CTRL, $urandom, $urandom});
    @(negedge i_clock);
    model_reset();
    checks++;
    if (o_valid !== 1'b0 || o_tx_scrambled !== 66'h0) begin
      errors++;
      $display("FAIL midreset_clear got=%h valid=%b exp=0", o_tx_scrambled, o_valid);
    end
    set_in(1'b0, 1'b1, 1'b1, 1'b0, {SH_DATA, 64'h0});
    @(negedge i_clock);
    checks++;
    if (o_valid !== 1'b1 || o_tx_scrambled !== {SH_DATA, 64'h0000_0000_01FF_FFC0}) begin
      errors++;
      $display("FAIL midreset_seed got=%h exp=%h", o_tx_scrambled, {SH_DATA, 64'h0000_0000_01FF_FFC0});
    end
    $display("reset_midstream: out=%h", o_tx_scrambled);
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 66'h0);
    model_reset();
    exp_data = 66'h0;
    @(negedge i_clock);
    test_reset();
    test_seed();
    test_hold();
    test_bypass();
    test_round_trip();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
